// File: rtl/pipe_adder_n.sv
// Pipelined ripple-carry add/subtract: WIDTH bits resolved SEG bits per stage,
// valid/ready handshake with whole-pipe stall, signed overflow on the last stage.
`timescale 1ns/1ps

module pipe_adder_n_seg #(
    parameter int SEG = 4
) (
    input  logic [SEG-1:0] a,
    input  logic [SEG-1:0] b,
    input  logic           ci,
    output logic [SEG-1:0] s,
    output logic           co,
    output logic           cm
);
    logic [SEG:0] c;

    always_comb begin
        s    = '0;
        c    = '0;
        c[0] = ci;
        for (int i = 0; i < SEG; i++) begin
            s[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
    end

    assign co = c[SEG];
    assign cm = c[SEG-1];
endmodule

module pipe_adder_n #(
    parameter int WIDTH = 16,
    parameter int SEG   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int STAGES = WIDTH / SEG;

    logic              adv;
    logic [STAGES-1:0] vld_q;
    logic [STAGES:0]   vld_pipe;

    // Operands are kept right-aligned: each stage consumes the low SEG bits
    // and shifts the unprocessed upper segments down for the next stage.
    logic [WIDTH-1:0] ain   [STAGES];
    logic [WIDTH-1:0] bin   [STAGES];
    logic [WIDTH-1:0] sin   [STAGES];
    logic             cyin  [STAGES];
    logic [WIDTH-1:0] opa_q [STAGES];
    logic [WIDTH-1:0] opb_q [STAGES];
    logic [WIDTH-1:0] sacc_q[STAGES];
    logic             cy_q  [STAGES];
    logic [SEG-1:0]   seg_s [STAGES];
    logic             seg_c [STAGES];
    logic             seg_m [STAGES];
    logic             ovf_q;

    assign vld_pipe  = {vld_q, in_valid};
    assign out_valid = vld_pipe[STAGES];
    assign adv       = !out_valid || out_ready;
    assign in_ready  = adv;

    always_comb begin
        ain[0]  = a;
        bin[0]  = sub ? ~b : b;
        sin[0]  = '0;
        cyin[0] = sub | cin;
        for (int k = 1; k < STAGES; k++) begin
            ain[k]  = opa_q[k-1];
            bin[k]  = opb_q[k-1];
            sin[k]  = sacc_q[k-1];
            cyin[k] = cy_q[k-1];
        end
    end

    for (genvar g = 0; g < STAGES; g++) begin : g_seg
        pipe_adder_n_seg #(.SEG(SEG)) u_seg (
            .a  (ain[g][SEG-1:0]),
            .b  (bin[g][SEG-1:0]),
            .ci (cyin[g]),
            .s  (seg_s[g]),
            .co (seg_c[g]),
            .cm (seg_m[g])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            ovf_q <= 1'b0;
            for (int k = 0; k < STAGES; k++) begin
                opa_q[k]  <= '0;
                opb_q[k]  <= '0;
                sacc_q[k] <= '0;
                cy_q[k]   <= 1'b0;
            end
        end else if (adv) begin
            vld_q <= vld_pipe[STAGES-1:0];
            // Data only loads behind a valid beat, so bubbles never disturb
            // the held result and idle X operands never enter the pipe.
            for (int k = 0; k < STAGES; k++) begin
                if (vld_pipe[k]) begin
                    opa_q[k]  <= ain[k] >> SEG;
                    opb_q[k]  <= bin[k] >> SEG;
                    sacc_q[k] <= sin[k] | (WIDTH'(seg_s[k]) << (k * SEG));
                    cy_q[k]   <= seg_c[k];
                end
            end
            if (vld_pipe[STAGES-1])
                ovf_q <= seg_m[STAGES-1] ^ seg_c[STAGES-1];
        end
    end

    assign sum  = sacc_q[STAGES-1];
    assign cout = cy_q[STAGES-1];
    assign ovf  = ovf_q;
endmodule
